cntr_cmd_sequencer: RTL

Hardware initiator for the Binary_Counter. It accepts high-level commands (LOAD, UP n, DOWN n, HOLD n) over a valid/ready port and drives the counter's Enable/Load/Count/Data_in cycle by cycle. It observes A_count and C_out and checks them against an internal predictor. It reports completion, error status and a carry tally per command. It sits between a host/test controller and the counter, replacing hand-driven control pins.

---
 rtl/cntr_cmd_sequencer_pkg.sv | 19 +
 rtl/cntr_cmd_sequencer_if.sv | 15 +
 rtl/cntr_cmd_sequencer_ref.sv | 42 ++++
 rtl/cntr_cmd_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cntr_cmd_sequencer_pkg.sv
// Shared types for the Binary_Counter command sequencer: opcodes and FSM states.
package cntr_seq_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        LOAD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/cntr_cmd_sequencer_if.sv
// Command port of the sequencer: valid/ready handshake carrying an opcode and argument.
interface cntr_cmd_sequencer_if #(
    parameter int LEN_W = 8
);
    import cntr_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [LEN_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/cntr_cmd_sequencer_ref.sv
// Reference model of the Binary_Counter: tracks the value and wrap flag the real counter should show.
module cntr_ref_model #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic             count_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] exp_o,
    output logic             expC_o
);

    logic [WIDTH-1:0] exp_q;
    logic             expC_q;

    // Load wins over Enable; the wrap flag only reflects the update just taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q  <= '0;
            expC_q <= 1'b0;
        end else if (load_i) begin
            exp_q  <= data_i;
            expC_q <= 1'b0;
        end else if (enable_i) begin
            if (count_i) begin
                exp_q  <= exp_q + WIDTH'(1);
                expC_q <= (exp_q == {WIDTH{1'b1}});
            end else begin
                exp_q  <= exp_q - WIDTH'(1);
                expC_q <= (exp_q == '0);
            end
        end else begin
            expC_q <= 1'b0;
        end
    end

    assign exp_o  = exp_q;
    assign expC_o = expC_q;

endmodule

// File: rtl/cntr_cmd_sequencer.sv
// Command sequencer for the Binary_Counter: turns LOAD/UP/DOWN/HOLD commands into per-cycle
// counter controls, checks the counter against a predictor and reports per-command results.
module cntr_cmd_sequencer
    import cntr_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8,
    parameter int ERR_W = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    cntr_cmd_sequencer_if.slave  cmd,
    output logic                 Enable,
    output logic                 Load,
    output logic                 Count,
    output logic [WIDTH-1:0]     Data_in,
    input  logic [WIDTH-1:0]     A_count,
    input  logic                 C_out,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [ERR_W-1:0]     carry_cnt,
    output logic                 mismatch,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_EXEC  = EXEC;
    localparam logic [1:0] S_FLUSH = FLUSH;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic             count_q;
    logic [ERR_W-1:0] carry_q, carrySum;
    logic [WIDTH-1:0] result_q;
    logic             chkEn_q;
    logic             mismatch_q;
    logic [ERR_W-1:0] errCnt_q;
    logic             accept;
    logic             execActive;
    logic [WIDTH-1:0] expVal;
    logic             expCarry;
    logic             cmpFail;

    assign cmd.cmd_ready = (state_q == S_IDLE) && reset;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // A zero-length UP/DOWN/HOLD skips EXEC and completes straight from FLUSH.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d   = (op_e'(cmd.cmd_op) == LOAD) ? LEN_W'(1) : cmd.cmd_arg;
                    state_d = (rem_d == '0) ? S_FLUSH : S_EXEC;
                end
            end
            S_EXEC: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            op_q    <= LOAD;
            data_q  <= '0;
            count_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (accept) begin
                op_q   <= op_e'(cmd.cmd_op);
                data_q <= cmd.cmd_arg[WIDTH-1:0];
                if (op_e'(cmd.cmd_op) == UP)   count_q <= 1'b1;
                if (op_e'(cmd.cmd_op) == DOWN) count_q <= 1'b0;
            end
        end
    end

    assign execActive = (state_q == S_EXEC);
    assign Load       = execActive && (op_q == LOAD);
    assign Enable     = execActive && ((op_q == UP) || (op_q == DOWN));
    assign Count      = count_q;
    assign Data_in    = Load ? data_q : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FLUSH);

    // The FLUSH cycle can itself show a wrap, so the reported tally includes it combinationally.
    assign carrySum  = (busy && C_out && (carry_q != {ERR_W{1'b1}})) ? carry_q + ERR_W'(1) : carry_q;
    assign carry_cnt = done ? carrySum : carry_q;
    assign result    = done ? A_count : result_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            if (accept)    carry_q <= '0;
            else if (busy) carry_q <= carrySum;
            if (done)      result_q <= A_count;
        end
    end

    cntr_ref_model #(.WIDTH(WIDTH)) u_ref (
        .clk      (CLK),
        .rst_n    (reset),
        .enable_i (Enable),
        .load_i   (Load),
        .count_i  (Count),
        .data_i   (Data_in),
        .exp_o    (expVal),
        .expC_o   (expCarry)
    );

    // The counter's contents are unknown until something has been loaded into it.
    assign cmpFail = chkEn_q && ((A_count != expVal) || (C_out != expCarry));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            chkEn_q    <= 1'b0;
            mismatch_q <= 1'b0;
            errCnt_q   <= '0;
        end else begin
            if (Load) chkEn_q <= 1'b1;
            if (cmpFail) begin
                mismatch_q <= 1'b1;
                if (errCnt_q != {ERR_W{1'b1}}) errCnt_q <= errCnt_q + ERR_W'(1);
            end
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = errCnt_q;

endmodule
